// File: rtl/sysid_pkg.sv
// ============================================================================
//  Module  : sysid_pkg
//  Brief   : Shared types and constants for the system-ID boot checker
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package sysid_pkg;

  localparam int SYSID_W = 32;

  // Avalon word addresses inside the system-ID slave
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } sysid_state_t;

  // Image match rule: ID must always agree; timestamp only when enabled
  function automatic logic sysid_match(
    input logic [SYSID_W-1:0] id,
    input logic [SYSID_W-1:0] ts,
    input logic [SYSID_W-1:0] exp_id,
    input logic [SYSID_W-1:0] exp_ts,
    input logic               check_ts
  );
    return (id == exp_id) && (!check_ts || (ts == exp_ts));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sysid_rd_timeout.sv
// ============================================================================
//  Module  : sysid_rd_timeout
//  Brief   : Saturating stall counter that flags a read which stalls too long
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sysid_rd_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] TERM    = CW'(LIMIT - 1);
  localparam logic [CW-1:0] SAT_VAL = CW'(LIMIT);

  logic [CW-1:0] count;

  // Count stalled cycles; clear has priority, and the count holds at LIMIT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT_VAL)) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th stalled cycle, so the edge that ends it is the
  // one on which the count would reach LIMIT and the read is abandoned.
  assign expired = enable && (count == TERM);

endmodule

`default_nettype wire

// File: rtl/sysid_boot_checker.sv
// ============================================================================
//  Module  : sysid_boot_checker
//  Brief   : Avalon-MM read master that fetches the system-ID and timestamp
//            words and compares them against build-time expectations
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_W-1:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [SYSID_W-1:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit                 CHECK_TS       = 1'b1,
  parameter int unsigned        TIMEOUT_CYCLES = 255,
  parameter bit                 AUTO_START     = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic               av_address,
  output logic               av_read,
  input  logic               av_waitrequest,
  input  logic [SYSID_W-1:0] av_readdata,
  output logic [SYSID_W-1:0] id_value,
  output logic [SYSID_W-1:0] ts_value,
  output logic               busy,
  output logic               done,
  output logic               id_match,
  output logic               timeout_err
);

  sysid_state_t state;
  logic         auto_pend;   // one-shot launch request for the first post-reset cycle
  logic         accept;
  logic         expired;

  assign accept = av_read && !av_waitrequest;

  // Stall timer restarts whenever no read is stalling: idle, done, or a read just completed
  sysid_rd_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!busy || accept),
    .enable  (busy && av_waitrequest),
    .expired (expired)
  );

  // Sequencer: state, bus outputs, status flags and capture registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      auto_pend   <= AUTO_START;
      av_read     <= 1'b0;
      av_address  <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_match    <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start || auto_pend) begin
            // Launching wipes the previous result on the same edge
            state       <= RD_ID;
            av_read     <= 1'b1;
            av_address  <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_match    <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        RD_ID, RD_TS: begin
          if (expired) begin
            // Abandon the stalled read; the uncaptured word keeps its cleared value
            state       <= DONE;
            av_read     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            id_match    <= 1'b0;
          end else if (accept) begin
            if (state == RD_ID) begin
              state      <= RD_TS;
              av_address <= SYSID_ADDR_TS;
              id_value   <= av_readdata;
            end else begin
              // Timestamp lands on this edge, so compare against the bus word directly
              state    <= DONE;
              av_read  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              ts_value <= av_readdata;
              id_match <= sysid_match(id_value, av_readdata, EXPECTED_ID,
                                      EXPECTED_TS, CHECK_TS);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
// ============================================================================
//  Module  : tb_sysid_boot_checker
//  Brief   : Self-checking bench for sysid_boot_checker
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sysid_boot_checker;

  localparam logic [31:0] GOOD_TS = 32'h67C0_1A84;

  typedef struct {
    bit          by_reset;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall_id;
    int          stall_ts;
    int          cycles;
    logic        match;
    logic        tout;
    logic [31:0] id_v;
    logic [31:0] ts_v;
  } vec_t;

  typedef struct {
    int          cycles;
    logic        match;
    logic        tout;
    logic [31:0] id_v;
    logic [31:0] ts_v;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  // DUT A: timestamp checked, short timeout, auto launch
  logic        adr_a, rd_a, wr_a, busy_a, done_a, match_a, to_a;
  logic [31:0] rdata_a, idv_a, tsv_a;
  logic [31:0] id_word_a = '0, ts_word_a = '0;
  int          stall_id_a = 0, stall_ts_a = 0, sc_a = 0;

  // DUT B: timestamp ignored, no auto launch, zero-wait slave
  logic        adr_b, rd_b, busy_b, done_b, match_b, to_b;
  logic [31:0] rdata_b, idv_b, tsv_b;
  logic [31:0] id_word_b = '0, ts_word_b = '0;

  sysid_boot_checker #(
    .EXPECTED_ID (32'h0000_0000), .EXPECTED_TS (GOOD_TS), .CHECK_TS (1'b1),
    .TIMEOUT_CYCLES (4), .AUTO_START (1'b1)
  ) dut_a (
    .clock (clock), .reset_n (reset_n), .start (start_a),
    .av_address (adr_a), .av_read (rd_a), .av_waitrequest (wr_a), .av_readdata (rdata_a),
    .id_value (idv_a), .ts_value (tsv_a), .busy (busy_a), .done (done_a),
    .id_match (match_a), .timeout_err (to_a)
  );

  sysid_boot_checker #(
    .EXPECTED_ID (32'h0000_0000), .EXPECTED_TS (GOOD_TS), .CHECK_TS (1'b0),
    .TIMEOUT_CYCLES (255), .AUTO_START (1'b0)
  ) dut_b (
    .clock (clock), .reset_n (reset_n), .start (start_b),
    .av_address (adr_b), .av_read (rd_b), .av_waitrequest (1'b0), .av_readdata (rdata_b),
    .id_value (idv_b), .ts_value (tsv_b), .busy (busy_b), .done (done_b),
    .id_match (match_b), .timeout_err (to_b)
  );

  // Slave model A: stalls each read for a configurable number of cycles
  always @(posedge clock) begin
    if (!rd_a || !wr_a) sc_a <= 0;
    else                sc_a <= sc_a + 1;
  end
  assign wr_a    = rd_a && (sc_a < (adr_a ? stall_ts_a : stall_id_a));
  assign rdata_a = adr_a ? ts_word_a : id_word_a;
  assign rdata_b = adr_b ? ts_word_b : id_word_b;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Launch one sequence on DUT A, follow it cycle by cycle, score the result
  task automatic run_a(input vec_t v);
    exp_t e;
    int   cyc;
    logic exp_adr;
    bit   seen;
    id_word_a  = v.id_word;
    ts_word_a  = v.ts_word;
    stall_id_a = v.stall_id;
    stall_ts_a = v.stall_ts;
    e.cycles = v.cycles; e.match = v.match; e.tout = v.tout;
    e.id_v = v.id_v; e.ts_v = v.ts_v;
    sb_q.push_back(e);
    @(negedge clock);
    if (v.by_reset) begin
      reset_n = 1'b0;
      #2;
      chk("rst_av_read", {31'd0, rd_a}, 32'd0);
      chk("rst_busy_done", {30'd0, busy_a, done_a}, 32'd0);
      chk("rst_match_to", {30'd0, match_a, to_a}, 32'd0);
      chk("rst_id_value", idv_a, 32'd0);
      chk("rst_ts_value", tsv_a, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
    end else begin
      start_a = 1'b1;
    end
    cyc = 0; exp_adr = 1'b0; seen = 1'b0;
    while (cyc < 40 && !seen) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      start_a = 1'b0;
      chk("busy_done_excl", {31'd0, busy_a & done_a}, 32'd0);
      if (rd_a) begin
        chk("av_address", {31'd0, adr_a}, {31'd0, exp_adr});
        if (!wr_a) exp_adr = 1'b1;
      end
      seen = done_a;
    end
    if (!seen) chk("done_wait_bound", {31'd0, done_a}, 32'd1);
    e = sb_q.pop_front();
    chk("done_cycles", 32'(cyc), 32'(e.cycles));
    chk("id_match", {31'd0, match_a}, {31'd0, e.match});
    chk("timeout_err", {31'd0, to_a}, {31'd0, e.tout});
    chk("id_value", idv_a, e.id_v);
    chk("ts_value", tsv_a, e.ts_v);
    chk("av_read_done", {30'd0, rd_a, busy_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    //          rst   id word         ts word         sid  sts  cyc match to  id_v           ts_v
    vecs[0] = '{1'b1, 32'h0,          GOOD_TS,        0,   0,   3,  1'b1, 1'b0, 32'h0,       GOOD_TS};
    vecs[1] = '{1'b0, 32'h1,          GOOD_TS,        0,   0,   3,  1'b0, 1'b0, 32'h1,       GOOD_TS};
    vecs[2] = '{1'b0, 32'h0,          GOOD_TS,        3,   3,   9,  1'b1, 1'b0, 32'h0,       GOOD_TS};
    vecs[3] = '{1'b0, 32'h0,          32'h67C0_1A85,  0,   0,   3,  1'b0, 1'b0, 32'h0,       32'h67C0_1A85};
    vecs[4] = '{1'b0, 32'h1,          GOOD_TS,        1,   255, 7,  1'b0, 1'b1, 32'h1,       32'h0};
    vecs[5] = '{1'b0, 32'hAAAA_5555,  GOOD_TS,        255, 0,   5,  1'b0, 1'b1, 32'h0,       32'h0};
    vecs[6] = '{1'b0, 32'h0,          GOOD_TS,        0,   3,   6,  1'b1, 1'b0, 32'h0,       GOOD_TS};

    for (int i = 0; i < 7; i++) run_a(vecs[i]);

    // DUT B has seen only resets: without auto launch it must still be idle
    chk("b_idle", {29'd0, rd_b, busy_b, done_b}, 32'd0);

    // Reset pulsed while DUT A waits in the timestamp read
    id_word_a = 32'h1; ts_word_a = GOOD_TS; stall_id_a = 0; stall_ts_a = 255;
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    begin
      bit got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clock);
        got = rd_a && adr_a;
      end
      chk("reach_rd_ts", {31'd0, got}, 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_av_read", {31'd0, rd_a}, 32'd0);
    chk("async_busy", {31'd0, busy_a}, 32'd0);
    chk("async_id_value", idv_a, 32'd0);
    chk("async_addr", {31'd0, adr_a}, 32'd0);
    run_a('{1'b1, 32'h0, GOOD_TS, 0, 0, 3, 1'b1, 1'b0, 32'h0, GOOD_TS});

    // DUT B: start during busy ignored; timestamp ignored for match
    id_word_b = 32'h0; ts_word_b = 32'h1234_5678;
    @(negedge clock); start_b = 1'b1;
    @(negedge clock);
    chk("b_busy", {31'd0, busy_b}, 32'd1);
    @(negedge clock); start_b = 1'b0;
    chk("b_no_restart_addr", {30'd0, rd_b, adr_b}, 32'd3);
    @(negedge clock);
    chk("b_done1", {30'd0, busy_b, done_b}, 32'd1);
    chk("b_match1", {31'd0, match_b}, 32'd1);
    chk("b_ts1", tsv_b, 32'h1234_5678);

    // Restart from DONE clears results on the launch edge
    ts_word_b = 32'h9ABC_DEF0;
    @(negedge clock); start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;
    chk("b_clear_flags", {29'd0, busy_b, done_b, match_b}, 32'd4);
    chk("b_clear_ts", tsv_b, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("b_done2", {31'd0, done_b}, 32'd1);
    chk("b_match2", {31'd0, match_b}, 32'd1);
    chk("b_ts2", tsv_b, 32'h9ABC_DEF0);

    // ID still decides the match with the timestamp check disabled
    id_word_b = 32'h5;
    @(negedge clock); start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("b_done3", {31'd0, done_b}, 32'd1);
    chk("b_match3", {31'd0, match_b}, 32'd0);
    chk("b_id3", idv_b, 32'h5);
    chk("b_to3", {31'd0, to_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
